// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake bundle for uart_tx_scheduler: one valid/ready pair
// and one byte lane per requester.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers.
// Frame and gap timing are derived from parameters because uart_tx has no busy flag.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CYCLES   = 2,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_scheduler_if.slave req_bus,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic              frame_done
);

  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
  localparam int CNT_MAX      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [7:0]        win_byte;
  logic [NUM_REQ-1:0] ready_vec;
  logic              handshake;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return ID_W'(sum);
  endfunction

  // Priority search starts at ptr so the last winner drops to lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_bus.req_valid[wrap_idx(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(ptr_q, i);
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (state_q == ST_IDLE && win_found) begin
      ready_vec[win_idx] = 1'b1;
    end
  end

  assign handshake        = (state_q == ST_IDLE) && win_found;
  assign win_byte         = req_bus.req_data[int'(win_idx) * 8 +: 8];
  assign req_bus.req_ready = ready_vec;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    tx_start   = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          tx_data_d  = win_byte;
          grant_id_d = win_idx;
          ptr_d      = wrap_idx(win_idx, 1);
          state_d    = ST_START;
        end
      end

      ST_START: begin
        tx_start = 1'b1;
        cnt_d    = FRAME_LOAD;
        state_d  = ST_WAIT;
      end

      // The counter reaches zero on the last cycle of frame time.
      ST_WAIT: begin
        if (cnt_q == '0) begin
          frame_done = 1'b1;
          if (GAP_CYCLES > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != ST_IDLE);

  // Structural invariants of the pacing sequence.
  a_start_done_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(tx_start && frame_done));

  a_start_only_in_start : assert property (
    @(posedge clk) disable iff (!rst_n) tx_start |-> (state_q == ST_START));

  a_ready_onehot : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(ready_vec));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus random
// traffic, all compared cycle by cycle against an age-based behavioural model.
module tb_uart_tx_scheduler;

  localparam int NREQ   = 4;
  localparam int CPB    = 4;
  localparam int FBITS  = 10;
  localparam int GAP    = 2;
  localparam int FRAME  = CPB * FBITS;
  localparam int PERIOD = FRAME + GAP + 2;

  typedef struct packed {
    logic [3:0] ready;
    logic       start;
    logic       done;
    logic       busy;
    logic [1:0] gid;
    logic [7:0] data;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_scheduler_if #(.NUM_REQ(NREQ)) bus0 ();
  uart_tx_scheduler_if #(.NUM_REQ(NREQ)) bus1 ();

  logic       tx_start0, busy0, frame_done0;
  logic [7:0] tx_data0;
  logic [1:0] grant_id0;
  logic       tx_start1, busy1, frame_done1;
  logic [7:0] tx_data1;
  logic [1:0] grant_id1;

  uart_tx_scheduler #(
    .NUM_REQ(NREQ), .CLKS_PER_BIT(CPB), .FRAME_BITS(FBITS), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_bus(bus0),
    .tx_start(tx_start0), .tx_data(tx_data0), .busy(busy0),
    .grant_id(grant_id0), .frame_done(frame_done0)
  );

  uart_tx_scheduler #(
    .NUM_REQ(NREQ), .CLKS_PER_BIT(CPB), .FRAME_BITS(FBITS), .GAP_CYCLES(0)
  ) dut_nogap (
    .clk(clk), .rst_n(rst_n), .req_bus(bus1),
    .tx_start(tx_start1), .tx_data(tx_data1), .busy(busy1),
    .grant_id(grant_id1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [3:0]  cur_v;
  logic [31:0] cur_d;
  obs_t        got, want;

  // Model: m_age is -1 while idle, otherwise cycles elapsed since the grant.
  int         m_age;
  int         m_ptr;
  int         m_gid;
  logic [7:0] m_data;

  function automatic int winner(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic obs_t model_obs(input logic [3:0] v);
    obs_t e;
    int   w;
    e = '0;
    if (m_age < 0) begin
      w = winner(v, m_ptr);
      if (w >= 0) e.ready[w] = 1'b1;
    end
    e.start = (m_age == 1);
    e.done  = (m_age == FRAME + 1);
    e.busy  = (m_age >= 1);
    e.gid   = 2'(m_gid);
    e.data  = m_data;
    return e;
  endfunction

  task automatic model_step(input logic [3:0] v, input logic [31:0] d);
    int w;
    if (m_age < 0) begin
      w = winner(v, m_ptr);
      if (w >= 0) begin
        m_data = d[8*w +: 8];
        m_gid  = w;
        m_ptr  = (w + 1) % NREQ;
        m_age  = 1;
      end
    end else begin
      m_age++;
      if (m_age == PERIOD) m_age = -1;
    end
  endtask

  task automatic model_reset();
    m_age  = -1;
    m_ptr  = 0;
    m_gid  = 0;
    m_data = 8'h00;
  endtask

  function automatic obs_t dut_obs();
    return {bus0.req_ready, tx_start0, frame_done0, busy0, grant_id0, tx_data0};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [31:0] d);
    cur_v          = v;
    cur_d          = d;
    bus0.req_valid = v;
    bus0.req_data  = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(4'b0000, 32'h0);
    bus1.req_valid = 4'b0000;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    #12;
    tests++;
    if (dut_obs() !== obs_t'(0)) begin
      failed++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", dut_obs(), obs_t'(0));
    end
    tests++;
    if ({bus1.req_ready, tx_start1, frame_done1, busy1, grant_id1, tx_data1} !== 17'h0) begin
      failed++;
      $display("[TB] FAIL reset_nogap got=%h exp=0",
               {bus1.req_ready, tx_start1, frame_done1, busy1, grant_id1, tx_data1});
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    for (int c = 0; c <= PERIOD + 2; c++) begin
      drive((c == 0) ? 4'b0001 : 4'b0000, 32'h3C7E_19A5);
      @(negedge clk);
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL single cyc=%0d got=%h exp=%h", c, got, want);
      end
      if (c == 0 || c == 1 || c == FRAME + 1 || c == PERIOD) begin
        tests++;
        if ((c == 0 && bus0.req_ready !== 4'b0001) ||
            (c == 1 && (tx_start0 !== 1'b1 || tx_data0 !== 8'hA5)) ||
            (c == FRAME + 1 && frame_done0 !== 1'b1) ||
            (c == PERIOD && busy0 !== 1'b0)) begin
          failed++;
          $display("[TB] FAIL single_milestone cyc=%0d got=%h", c, got);
        end
      end
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_all_four();
    int gids[$];
    int gcyc[$];
    int eid[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c <= 4 * PERIOD; c++) begin
      drive(4'b1111, 32'h4332_2110);
      @(negedge clk);
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL all_four cyc=%0d got=%h exp=%h", c, got, want);
      end
      if ((bus0.req_ready & cur_v) != 4'b0) begin
        gids.push_back(onehot_idx(bus0.req_ready & cur_v));
        gcyc.push_back(c);
      end
      if (tx_start0 === 1'b1) begin
        tests++;
        if (tx_data0 !== 8'h10 + 8'h11 * {6'b0, grant_id0}) begin
          failed++;
          $display("[TB] FAIL all_four_data cyc=%0d got=%h exp=%h", c, tx_data0,
                   8'h10 + 8'h11 * {6'b0, grant_id0});
        end
      end
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= gids.size() || gids[i] != eid[i] || gcyc[i] != i * PERIOD) begin
        failed++;
        $display("[TB] FAIL all_four_order idx=%0d got=%0d@%0d exp=%0d@%0d", i,
                 (i < gids.size()) ? gids[i] : -1, (i < gcyc.size()) ? gcyc[i] : -1,
                 eid[i], i * PERIOD);
      end
    end
  endtask

  task automatic test_rotation();
    int gids[$];
    int gcyc[$];
    int eid[3] = '{2, 3, 1};
    logic [3:0] v;
    do_reset();
    for (int c = 0; c < 3 * PERIOD; c++) begin
      v = (c == 0) ? 4'b0100 : ((c >= PERIOD && c <= 2 * PERIOD) ? 4'b1010 : 4'b0000);
      drive(v, 32'hD4C3_B2A1);
      @(negedge clk);
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL rotation cyc=%0d got=%h exp=%h", c, got, want);
      end
      if ((bus0.req_ready & cur_v) != 4'b0) begin
        gids.push_back(onehot_idx(bus0.req_ready & cur_v));
        gcyc.push_back(c);
      end
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
    end
    tests++;
    if (gids.size() != 3) begin
      failed++;
      $display("[TB] FAIL rotation_count got=%0d exp=3", gids.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= gids.size() || gids[i] != eid[i] || gcyc[i] != i * PERIOD) begin
        failed++;
        $display("[TB] FAIL rotation_order idx=%0d got=%0d exp=%0d", i,
                 (i < gids.size()) ? gids[i] : -1, eid[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    bus1.req_data  = 32'h0000_005A;
    bus1.req_valid = 4'b0001;
    for (int c = 0; c < 200 && starts.size() < 3; c++) begin
      @(negedge clk);
      if (tx_start1 === 1'b1) starts.push_back(c);
      @(posedge clk); #1;
    end
    bus1.req_valid = 4'b0000;
    tests++;
    if (starts.size() < 3) begin
      failed++;
      $display("[TB] FAIL b2b_pulses got=%0d exp=3", starts.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (starts[i] - starts[i-1] != FRAME + 2) begin
          failed++;
          $display("[TB] FAIL b2b_spacing idx=%0d got=%0d exp=%0d", i,
                   starts[i] - starts[i-1], FRAME + 2);
        end
      end
    end
    repeat (FRAME + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_wait();
    int n_start;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive((c == 0) ? 4'b0100 : 4'b0000, 32'h11_22_33_44);
      @(negedge clk);
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL midreset_pre cyc=%0d got=%h exp=%h", c, got, want);
      end
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (dut_obs() !== obs_t'(0)) begin
      failed++;
      $display("[TB] FAIL midreset_clear got=%h exp=%h", dut_obs(), obs_t'(0));
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_start = 0;
    for (int c = 0; c < 60; c++) begin
      drive(4'b0000, 32'h11_22_33_44);
      @(negedge clk);
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL midreset_post cyc=%0d got=%h exp=%h", c, got, want);
      end
      if (tx_start0 === 1'b1) n_start++;
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
    end
    tests++;
    if (n_start != 0) begin
      failed++;
      $display("[TB] FAIL midreset_nostart got=%0d exp=0", n_start);
    end
    for (int c = 0; c <= PERIOD; c++) begin
      drive((c == 0) ? 4'b1111 : 4'b0000, 32'h99_88_77_66);
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if (bus0.req_ready !== 4'b0001) begin
          failed++;
          $display("[TB] FAIL midreset_ptr got=%b exp=0001", bus0.req_ready);
        end
      end
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL midreset_regrant cyc=%0d got=%h exp=%h", c, got, want);
      end
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_withdrawn();
    logic [3:0] ready_seen;
    ready_seen = 4'b0;
    do_reset();
    for (int c = 0; c <= PERIOD + 5; c++) begin
      if (c == 0)                drive(4'b0001, 32'h00_00_BB_CC);
      else if (c >= 10 && c <= 30) drive(4'b0010, 32'h00_00_BB_CC);
      else                       drive(4'b0000, 32'h00_00_BB_CC);
      @(negedge clk);
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL withdrawn cyc=%0d got=%h exp=%h", c, got, want);
      end
      if (c > 0) ready_seen = ready_seen | bus0.req_ready;
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
    end
    tests++;
    if (ready_seen !== 4'b0000 || grant_id0 !== 2'd0) begin
      failed++;
      $display("[TB] FAIL withdrawn_nogrant ready=%b gid=%0d exp ready=0000 gid=0",
               ready_seen, grant_id0);
    end
  endtask

  task automatic test_random();
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  hs;
    v = 4'b0;
    d = $urandom;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      drive(v, d);
      @(negedge clk);
      got = dut_obs(); want = model_obs(cur_v); tests++;
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL random cyc=%0d v=%b got=%h exp=%h", c, cur_v, got, want);
      end
      hs = bus0.req_ready & cur_v;
      model_step(cur_v, cur_d);
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (hs[k]) begin
          v[k] = 1'b0;
        end else if (v[k]) begin
          if ($urandom_range(0, 39) == 0) v[k] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          v[k]        = 1'b1;
          d[8*k +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    bus0.req_valid = 4'b0;
    bus0.req_data  = 32'h0;
    bus1.req_valid = 4'b0;
    bus1.req_data  = 32'h0;
    cur_v = 4'b0;
    cur_d = 32'h0;
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_rotation();
    test_back_to_back();
    test_reset_mid_wait();
    test_withdrawn();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
